hermes_input_buffer: RTL

- Per-port input FIFO for the Hermes router, placed between a neighbour's link (or the local PE) and the central switch control.
- Stores incoming flits and requests routing for each packet header (req/ack).
- Streams header, size and payload flits to the crossbar while holding `sending_o` high.
- Drops `sending_o` after the last flit, which is the event the switch control uses to free the output port.

---
 rtl/hermes_input_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input buffer: circular flit FIFO plus a packet FSM that
// requests routing for each header and streams header, size and payload to the crossbar.
module hermes_input_buffer #(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 req_o,
   input  logic                 ack_i,
   output logic                 sending_o,
   output logic                 tx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(BUFFER_SIZE);

   typedef enum logic [2:0] {IDLE, REQ, HEADER, SIZE, PAYLOAD} state_t;

   state_t               state_reg, state_next;
   logic [PTR_W-1:0]     rd_ptr_reg, wr_ptr_reg;
   logic [PTR_W:0]       count_reg;
   logic [FLIT_SIZE-1:0] flit_cnt_reg, flit_cnt_next;
   logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
   logic                 push, pop, tx, fifo_empty;

   assign fifo_empty = (count_reg == '0);
   assign credit_o   = (count_reg != FULL_COUNT);
   assign push       = rx_i && credit_o;
   assign pop        = tx && credit_i;
   assign tx_o       = tx;
   assign data_o     = mem[rd_ptr_reg];

   // Storage carries no reset; contents are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         flit_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         flit_cnt_reg <= flit_cnt_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next    = state_reg;
      flit_cnt_next = flit_cnt_reg;
      tx            = 1'b0;
      req_o         = 1'b0;
      sending_o     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) state_next = REQ;
         end
         REQ: begin
            req_o = 1'b1;
            if (ack_i) state_next = HEADER;
         end
         HEADER: begin
            sending_o = 1'b1;
            tx        = 1'b1;
            if (pop) state_next = SIZE;
         end
         SIZE: begin
            sending_o = 1'b1;
            tx        = !fifo_empty;
            if (pop) begin
               flit_cnt_next = data_o;
               // A zero-length packet ends right after its size flit.
               state_next    = (data_o == '0) ? IDLE : PAYLOAD;
            end
         end
         PAYLOAD: begin
            sending_o = 1'b1;
            tx        = !fifo_empty;
            if (pop) begin
               flit_cnt_next = flit_cnt_reg - 1'b1;
               if (flit_cnt_reg == FLIT_SIZE'(1)) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
